// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: input filtering, 11-bit frame deframing with odd parity,
// and E0/F0 prefix decoding into key make/break events.
module ps2_rx #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       rx_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_pressed,
    output logic       key_strobe,
    output logic       busy
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_meta, clk_sync, data_meta, data_sync;
    logic          clk_f, clk_f_d, fall;
    logic [FW-1:0] filt_cnt;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par_ok;
    logic [TW-1:0] tcnt;
    logic          ext_pend, rel_pend;

    // Lines idle high, so the input stage resets to the idle level to avoid a phantom edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
            clk_f     <= 1'b1;
            clk_f_d   <= 1'b1;
            filt_cnt  <= '0;
            fall      <= 1'b0;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
            if (clk_sync != clk_f) begin
                if (filt_cnt == FW'(FILTER - 1)) begin
                    clk_f    <= clk_sync;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
            clk_f_d <= clk_f;
            fall    <= clk_f_d & ~clk_f;
        end
    end

    // Frame FSM; a filtered falling edge always takes priority over the timeout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sr        <= '0;
            par_ok    <= 1'b0;
            tcnt      <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sr      <= {data_sync, sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{sr, data_sync};
                        state  <= STOP;
                    end
                    STOP: begin
                        if (data_sync && par_ok) begin
                            rx_byte   <= sr;
                            rx_strobe <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
                state  <= IDLE;
                rx_err <= 1'b1;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Prefix decoder runs one cycle behind the byte strobe.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext_pend    <= 1'b0;
            rel_pend    <= 1'b0;
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_pressed <= 1'b0;
            key_strobe  <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_err) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end else if (rx_strobe) begin
                case (rx_byte)
                    8'hE0: ext_pend <= 1'b1;
                    8'hF0: rel_pend <= 1'b1;
                    default: begin
                        key_code    <= rx_byte;
                        key_ext     <= ext_pend;
                        key_pressed <= ~rel_pend;
                        key_strobe  <= 1'b1;
                        ext_pend    <= 1'b0;
                        rel_pend    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: a PS/2 frame driver feeds the DUT while a monitor
// pops expected byte/error and key events from queues filled by a prefix-decoding model.
module tb_ps2_rx;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 20000;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_pressed;
    logic       key_strobe;
    logic       busy;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_strobe  (rx_strobe),
        .rx_err     (rx_err),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_pressed(key_pressed),
        .key_strobe (key_strobe),
        .busy       (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // kind: 0 = good byte, 1 = parity/stop error, 2 = timeout error
    typedef struct {
        int         kind;
        logic [7:0] val;
        longint     ref_cyc;
    } rx_ev_t;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       pressed;
    } key_ev_t;

    rx_ev_t     rx_q[$];
    key_ev_t    key_q[$];
    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    longint     last_fall = 0;
    longint     last_rx_cyc = -10;
    logic [7:0] m_last_byte = 8'h00;
    logic       m_ext = 1'b0;
    logic       m_rel = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Reference model: byte-level rules of the receiver and prefix decoder.
    task automatic push_frame(input logic [7:0] b, input logic good, input longint refc);
        rx_ev_t  e;
        key_ev_t k;
        if (good) begin
            e = '{0, b, refc};
            rx_q.push_back(e);
            m_last_byte = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                k = '{b, m_ext, ~m_rel};
                key_q.push_back(k);
                m_ext = 1'b0;
                m_rel = 1'b0;
            end
        end else begin
            e = '{1, m_last_byte, refc};
            rx_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    // High half-period (data changes mid-high, optional 3-cycle glitch), then falling edge.
    task automatic drive_bit(input logic b, input logic glitch);
        tick(50);
        ps2_data = b;
        if (glitch) begin
            tick(20);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(27);
        end else begin
            tick(50);
        end
        ps2_clk   = 1'b0;
        last_fall = cyc + 1;
    endtask

    task automatic release_clk();
        tick(100);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_b,
                              input int glitch_bit);
        logic        p;
        logic [10:0] bits;
        p    = (~^b) ^ bad_par;
        bits = {stop_b, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive_bit(bits[i], i == glitch_bit);
            if (i == 10) push_frame(b, !bad_par && stop_b, last_fall);
            release_clk();
        end
    endtask

    task automatic send_partial(input int n_data);
        drive_bit(1'b0, 1'b0);
        release_clk();
        for (int i = 0; i < n_data; i++) begin
            drive_bit(1'($urandom_range(0, 1)), 1'b0);
            release_clk();
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || key_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, rx_q.size() + key_q.size(), 0);
        rx_q.delete();
        key_q.delete();
    endtask

    task automatic check_output(input string name, input logic [7:0] e_rx, input logic [7:0] e_key,
                                input logic e_ext, input logic e_pressed, input logic e_busy);
        check({name, "_rx_byte"}, rx_byte, e_rx);
        check({name, "_key_code"}, key_code, e_key);
        check({name, "_key_ext"}, key_ext, e_ext);
        check({name, "_key_pressed"}, key_pressed, e_pressed);
        check({name, "_busy"}, busy, e_busy);
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clk_sys) begin
        rx_ev_t  e;
        key_ev_t k;
        if (!reset) begin
            if (rx_strobe && rx_err) check("strobe_and_err_together", 1, 0);
            if (rx_strobe || rx_err) begin
                if (rx_q.size() == 0) begin
                    check("unexpected_rx_event", rx_strobe ? 32'h100 + rx_byte : 32'hE77, 0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_kind_is_err", rx_err, e.kind != 0);
                    check("rx_byte", rx_byte, e.val);
                    if (e.kind < 2) begin
                        check("rx_latency", cyc - e.ref_cyc, FILTER + 3);
                    end else begin
                        check("timeout_latency_in_range",
                              (cyc - e.ref_cyc >= TIMEOUT) && (cyc - e.ref_cyc <= TIMEOUT + FILTER + 4), 1);
                    end
                end
                if (rx_strobe) last_rx_cyc = cyc;
            end
            if (key_strobe) begin
                if (key_q.size() == 0) begin
                    check("unexpected_key_event", key_code, 32'h1FF);
                end else begin
                    k = key_q.pop_front();
                    check("key_code", key_code, k.code);
                    check("key_ext", key_ext, k.ext);
                    check("key_pressed", key_pressed, k.pressed);
                    check("key_after_rx", cyc - last_rx_cyc, 1);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rx_ev_t e;
        logic [7:0] b;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(10);
        check_output("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_rx_strobe", rx_strobe, 0);
        check("reset_key_strobe", key_strobe, 0);
        reset = 1'b0;
        tick(20);

        $display("[TB] single make code 1C");
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        wait_drain("drain_1c", 500);
        check_output("after_1c", 8'h1C, 8'h1C, 1'b0, 1'b1, 1'b0);

        $display("[TB] extended break E0 F0 75");
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        wait_drain("drain_e0f075", 500);

        $display("[TB] parity and stop errors");
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        wait_drain("drain_errs", 500);
        check("rx_byte_held", rx_byte, 8'h75);

        $display("[TB] clock glitches");
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(30);
        check("idle_glitch_busy", busy, 0);
        send_frame(8'h29, 1'b0, 1'b1, 4);
        wait_drain("drain_glitch", 500);

        $display("[TB] timeout");
        send_partial(5);
        check("partial_busy", busy, 1);
        e = '{2, m_last_byte, last_fall};
        rx_q.push_back(e);
        m_ext = 1'b0;
        m_rel = 1'b0;
        wait_drain("drain_timeout", TIMEOUT + 1000);
        check("timeout_busy", busy, 0);
        send_frame(8'h29, 1'b0, 1'b1, -1);
        wait_drain("drain_after_to", 500);
        check("rx_byte_after_to", rx_byte, 8'h29);

        $display("[TB] reset mid-frame after F0");
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_partial(3);
        tick(50);
        reset = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
        m_last_byte = 8'h00;
        tick(3);
        check_output("midframe_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_drain("drain_reset", 1);
        reset = 1'b0;
        tick(20);
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        wait_drain("drain_post_reset", 500);
        check("post_reset_pressed", key_pressed, 1);

        $display("[TB] randomized frames");
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, $urandom_range(0, 5) == 0, $urandom_range(0, 7) != 0, -1);
        end
        wait_drain("drain_random", 500);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
